// File: rtl/compare_seq.sv
// compare_seq: multi-cycle magnitude/equality comparator.
// Scans the operands CHUNK bits at a time from the most significant chunk
// down and stops on the first chunk that differs. Signed compares are turned
// into unsigned ones by flipping the sign bit of both operands at capture.
module compare_seq #(
   parameter int BUS_SIZE = 16,
   parameter int CHUNK    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                signed_mode,
   input  logic [BUS_SIZE-1:0] a,
   input  logic [BUS_SIZE-1:0] b,
   output logic                busy,
   output logic                done,
   output logic                eq,
   output logic                lt,
   output logic                gt
);

   localparam int N     = BUS_SIZE / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [BUS_SIZE-1:0] a_q, a_d;
   logic [BUS_SIZE-1:0] b_q, b_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                eq_q, eq_d;
   logic                lt_q, lt_d;
   logic                gt_q, gt_d;

   logic [CHUNK-1:0]    a_chunk;
   logic [CHUNK-1:0]    b_chunk;
   int                  base;

   // Next-state logic: capture operands in IDLE, walk chunks MSB-first in SCAN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      lt_d    = lt_q;
      gt_d    = gt_q;

      base    = int'(idx_q) * CHUNK;
      a_chunk = a_q[base +: CHUNK];
      b_chunk = b_q[base +: CHUNK];

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d = a;
               b_d = b;
               if (signed_mode) begin
                  a_d[BUS_SIZE-1] = ~a[BUS_SIZE-1];
                  b_d[BUS_SIZE-1] = ~b[BUS_SIZE-1];
               end
               idx_d   = IDX_W'(N - 1);
               state_d = SCAN;
               busy_d  = 1'b1;
            end
         end
         SCAN: begin
            if (a_chunk != b_chunk) begin
               gt_d    = (a_chunk > b_chunk);
               lt_d    = !(a_chunk > b_chunk);
               eq_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               eq_d    = 1'b1;
               lt_d    = 1'b0;
               gt_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers; reset aborts any scan in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign eq   = eq_q;
   assign lt   = lt_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_compare_seq.sv
// tb_compare_seq: directed and randomized checks of compare_seq.
// One instance uses the default 16/4 geometry, a second one uses 16/8 for
// the randomized sweep. Expected results come from plain integer compares.
module tb_compare_seq;

   logic        clk;
   logic        rst;

   logic        start, signed_mode, busy, done, eq, lt, gt;
   logic [15:0] a, b;

   logic        r_start, r_signed_mode, r_busy, r_done, r_eq, r_lt, r_gt;
   logic [15:0] r_a, r_b;

   int vectors;
   int miscompares;

   compare_seq #(.BUS_SIZE(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
   );

   compare_seq #(.BUS_SIZE(16), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .start(r_start), .signed_mode(r_signed_mode),
      .a(r_a), .b(r_b), .busy(r_busy), .done(r_done), .eq(r_eq), .lt(r_lt), .gt(r_gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: number of chunks examined = position of first differing chunk from the top
   function automatic int exp_lat(input logic [15:0] x, input logic [15:0] y, input int chunk);
      logic [15:0] diff;
      diff = x ^ y;
      if (diff == 16'h0) return 16 / chunk;
      for (int i = 15; i >= 0; i--) begin
         if (diff[i]) return (15 - i) / chunk + 1;
      end
      return 16 / chunk;
   endfunction

   // Reference: {eq, lt, gt} from integer compare
   function automatic logic [2:0] exp_res(input logic [15:0] x, input logic [15:0] y, input logic sm);
      logic l;
      if (x == y) return 3'b100;
      l = sm ? ($signed(x) < $signed(y)) : (x < y);
      return l ? 3'b010 : 3'b001;
   endfunction

   // Runs one compare from a negedge; returns at the negedge where done is seen.
   // lat = SCAN edges until done (-1 on timeout), busy_n = busy samples before done,
   // done0 = done sampled in the cycle right after the accepting edge.
   task automatic do_cmp(input bit which, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, output int lat, output int busy_n,
                         output logic done0, output logic [2:0] res);
      logic d, bz;
      if (which) begin
         r_a = av; r_b = bv; r_signed_mode = sm; r_start = 1'b1;
      end else begin
         a = av; b = bv; signed_mode = sm; start = 1'b1;
      end
      @(negedge clk);
      r_start = 1'b0;
      start   = 1'b0;
      done0   = which ? r_done : done;
      bz      = which ? r_busy : busy;
      busy_n  = bz ? 1 : 0;
      lat     = 0;
      d       = 1'b0;
      while (!d && lat < 20) begin
         @(negedge clk);
         lat++;
         d  = which ? r_done : done;
         bz = which ? r_busy : busy;
         if (!d && bz) busy_n++;
      end
      if (!d) lat = -1;
      res = which ? {r_eq, r_lt, r_gt} : {eq, lt, gt};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors += 5;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
      if (eq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_eq got %b want 0", eq); end
      if (lt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_lt got %b want 0", lt); end
      if (gt !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_gt got %b want 0", gt); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_equal();
      int lat, bn; logic d0; logic [2:0] res;
      do_cmp(1'b0, 16'h1234, 16'h1234, 1'b0, lat, bn, d0, res);
      vectors += 4;
      if (lat !== 4) begin miscompares++; $display("[TB] FAIL equal_lat got %0d want 4", lat); end
      if (bn !== 4) begin miscompares++; $display("[TB] FAIL equal_busy got %0d want 4", bn); end
      if (res !== 3'b100) begin miscompares++; $display("[TB] FAIL equal_res got %b want 100", res); end
      @(negedge clk);
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL equal_pulse got %b want 0", done); end
   endtask

   task automatic test_msb();
      int lat, bn; logic d0; logic [2:0] res;
      do_cmp(1'b0, 16'h8000, 16'h7FFF, 1'b0, lat, bn, d0, res);
      vectors += 3;
      if (d0 !== 1'b0) begin miscompares++; $display("[TB] FAIL msb_u_done0 got %b want 0", d0); end
      if (lat !== 1) begin miscompares++; $display("[TB] FAIL msb_u_lat got %0d want 1", lat); end
      if (res !== 3'b001) begin miscompares++; $display("[TB] FAIL msb_u_res got %b want 001", res); end
      @(negedge clk);
      do_cmp(1'b0, 16'h8000, 16'h7FFF, 1'b1, lat, bn, d0, res);
      vectors += 2;
      if (lat !== 1) begin miscompares++; $display("[TB] FAIL msb_s_lat got %0d want 1", lat); end
      if (res !== 3'b010) begin miscompares++; $display("[TB] FAIL msb_s_res got %b want 010", res); end
      @(negedge clk);
   endtask

   task automatic test_lsb();
      int lat, bn; logic d0; logic [2:0] res;
      do_cmp(1'b0, 16'h1234, 16'h1235, 1'b0, lat, bn, d0, res);
      vectors += 2;
      if (lat !== 4) begin miscompares++; $display("[TB] FAIL lsb_lat got %0d want 4", lat); end
      if (res !== 3'b010) begin miscompares++; $display("[TB] FAIL lsb_res got %b want 010", res); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc;
      int lat, bn; logic d0; logic [2:0] res;
      a = 16'h0001; b = 16'h0001; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 16'hFFFF;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
      start = 1'b0;
      vectors += 2;
      if (cyc !== 4) begin miscompares++; $display("[TB] FAIL busy_ignore_lat got %0d want 4", cyc); end
      if ({eq, lt, gt} !== 3'b100) begin miscompares++; $display("[TB] FAIL busy_ignore_res got %b want 100", {eq, lt, gt}); end
      do_cmp(1'b0, 16'h0002, 16'h0001, 1'b0, lat, bn, d0, res);
      vectors += 4;
      if (d0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_gap got %b want 0", d0); end
      if (bn !== 4) begin miscompares++; $display("[TB] FAIL b2b_busy got %0d want 4", bn); end
      if (lat !== 4) begin miscompares++; $display("[TB] FAIL b2b_lat got %0d want 4", lat); end
      if (res !== 3'b001) begin miscompares++; $display("[TB] FAIL b2b_res got %b want 001", res); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, bn, seen; logic d0; logic [2:0] res;
      do_cmp(1'b0, 16'h1234, 16'h1234, 1'b0, lat, bn, d0, res);
      vectors += 1;
      if (res !== 3'b100) begin miscompares++; $display("[TB] FAIL rmid_pre_res got %b want 100", res); end
      @(negedge clk);
      a = 16'h00F0; b = 16'h00F1; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors += 3;
      if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_busy got %b want 0", busy); end
      if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_done got %b want 0", done); end
      if ({eq, lt, gt} !== 3'b000) begin miscompares++; $display("[TB] FAIL rmid_res got %b want 000", {eq, lt, gt}); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
      vectors += 1;
      if (seen !== 0) begin miscompares++; $display("[TB] FAIL rmid_after got %0d want 0", seen); end
   endtask

   task automatic test_random();
      int lat, bn; logic d0; logic [2:0] res;
      logic [15:0] x, y; logic sm; int el; logic [2:0] er;
      for (int i = 0; i < 1000; i++) begin
         x  = 16'($urandom);
         y  = 16'($urandom);
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = {x[15:8], y[7:0]};
            default: ;
         endcase
         sm = 1'($urandom);
         el = exp_lat(x, y, 8);
         er = exp_res(x, y, sm);
         do_cmp(1'b1, x, y, sm, lat, bn, d0, res);
         vectors += 3;
         if (res !== er) begin miscompares++; $display("[TB] FAIL rand_res a=%h b=%h s=%b got %b want %b", x, y, sm, res, er); end
         if (lat !== el) begin miscompares++; $display("[TB] FAIL rand_lat a=%h b=%h got %0d want %0d", x, y, lat, el); end
         if (d0 !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_done_gap got %b want 0", d0); end
      end
   endtask

   // Guard against a hung handshake
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Test sequence
   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1;
      start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      r_start = 1'b0; r_signed_mode = 1'b0; r_a = '0; r_b = '0;
      test_reset();
      test_equal();
      test_msb();
      test_lsb();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/compare_seq.md
Name: compare_seq

Overview:
- Multi-cycle magnitude/equality comparator for the math component set; the sequential counterpart of the combinational equality check.
- Compares two BUS_SIZE operands CHUNK bits per cycle, scanning from the MSB chunk downward, with early termination on the first differing chunk.
- Reports eq/lt/gt, unsigned or signed, behind a start/busy/done handshake.
- Used by the ALU / branch logic where a full-width single-cycle compare path is too long.

Parameters:
- BUS_SIZE, 16, operand width in bits.
- CHUNK, 4, bits compared per cycle. Must divide BUS_SIZE. N = BUS_SIZE/CHUNK chunks.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a compare; sampled only when busy=0.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  BUS_SIZE  left operand; captured on the accepting edge.
- b  input  BUS_SIZE  right operand; captured on the accepting edge.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when the result registers update.
- eq  output  1  a == b.
- lt  output  1  a < b.
- gt  output  1  a > b.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, eq=0, lt=0, gt=0; chunk index and operand registers = 0. Deassertion needs no special sequencing.
- States:
  - IDLE: busy=0.
  - SCAN: busy=1.
- IDLE with start=1 at edge E0:
  - Latch a, b and signed_mode.
  - If signed_mode=1, invert bit BUS_SIZE-1 of both latched operands. Unsigned compare of the inverted values equals the signed compare.
  - idx = N-1; go to SCAN.
  - done is 0 in the cycle after E0.
- SCAN, each edge, compare chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK):
  - Chunks differ: gt = (a_chunk > b_chunk), lt = !gt, eq = 0; done=1 for one cycle; go to IDLE.
  - Chunks equal and idx == 0: eq=1, lt=0, gt=0; done=1; go to IDLE.
  - Chunks equal and idx > 0: idx = idx-1; stay in SCAN.
- Latency: done is high in the cycle after the k-th SCAN edge, where k = chunks examined (1..N). Worst case is N SCAN edges. With defaults, 4 cycles from start-accept to done.
- Result registers:
  - eq/lt/gt change only on the edge that raises done; hold until the next done.
  - Exactly one of eq/lt/gt is 1 after the first completed compare; all are 0 before it.
- start while busy=1 is ignored: no queuing, operands unchanged.
- start in the same cycle done=1 (state already IDLE) is accepted: back-to-back operation, no bubble.
- Inputs a, b and signed_mode may change freely while busy=1 without effect.
- rst asserted mid-scan aborts immediately to the reset values. No done is produced for the aborted compare.
- done is a registered pulse, never high for two consecutive cycles. Back-to-back compares still separate their done pulses by at least one low cycle.

Test Plan:
- Equal operands: unsigned, a=0x1234, b=0x1234, start one cycle -> busy for 4 cycles, then done pulse with eq=1, lt=0, gt=0.
- MSB early exit and signed mode:
  - a=0x8000, b=0x7FFF, signed_mode=0 -> done after 1 SCAN cycle, gt=1.
  - Same operands with signed_mode=1 -> done after 1 SCAN cycle, lt=1.
- LSB decision: unsigned, a=0x1234, b=0x1235 -> done after 4 SCAN cycles, lt=1, gt=0, eq=0.
- Busy and back-to-back start:
  - Start a=0x0001, b=0x0001; drive start=1 with a=0xFFFF during busy -> ignored, result eq=1.
  - Then assert start with a=0x0002, b=0x0001 in the done cycle -> accepted, next done gives gt=1.
- Reset mid-scan: after result eq=1, start a=0x00F0, b=0x00F1; assert rst during the 2nd SCAN cycle -> busy=0, done=0, eq=lt=gt=0 immediately; no done after rst release.
- Randomized sweep with BUS_SIZE=16, CHUNK=8, 1000 random signed and unsigned pairs -> eq/lt/gt match a reference compare; latency matches the position of the first differing byte.
